system_bus_arbiter: RTL

//  N-master arbiter for the shared system bus (replaces the fixed fetch/load-store mux in cpu).

---
 rtl/system_bus_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/system_bus_arbiter.sv
// Shared system bus arbiter: fixed-priority or round-robin grant across N masters, with an
// in-order ID FIFO that steers each read return back to the master that issued it.

package system_bus_arbiter_pkg;
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;
endpackage

// Per-master slice: eligibility plus its request masked by grant, so the bus mux is a plain OR.
module system_bus_arb_lane
  import system_bus_arbiter_pkg::*;
(
  input  logic        grant,
  input  logic        fifo_full,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [29:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  output logic        eligible,
  output bus_req_t    bus_req
);
  assign eligible      = (read_req & ~fifo_full) | write_req;
  assign bus_req.rd    = grant & read_req;
  assign bus_req.wr    = grant & write_req;
  assign bus_req.addr  = addr & {30{grant}};
  assign bus_req.wdata = write_data & {32{grant}};
  assign bus_req.be    = byte_enable & {4{grant}};
endmodule

module system_bus_arbiter
  import system_bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS     = 2,
  parameter  int ARB_MODE        = 0,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int ID_W            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    mst_read_req,
  input  logic [NUM_MASTERS-1:0]    mst_write_req,
  input  logic [NUM_MASTERS*30-1:0] mst_addr,
  input  logic [NUM_MASTERS*32-1:0] mst_write_data,
  input  logic [NUM_MASTERS*4-1:0]  mst_byte_enable,
  output logic [NUM_MASTERS-1:0]    mst_ready,
  output logic [31:0]               mst_read_data,
  output logic [NUM_MASTERS-1:0]    mst_read_data_valid,
  input  logic                      system_bus_ready,
  output logic [29:0]               system_bus_addr,
  output logic [31:0]               system_bus_write_data,
  output logic [3:0]                system_bus_byte_enable,
  output logic                      system_bus_read_req,
  output logic                      system_bus_write_req,
  input  logic [31:0]               system_bus_read_data,
  input  logic                      system_bus_read_data_valid,
  output logic [CNT_W-1:0]          outstanding_count,
  output logic                      unexpected_read_error
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [NUM_MASTERS-1:0] eligible, grant;
  bus_req_t [NUM_MASTERS-1:0] lane_req;
  bus_req_t bus;
  logic fifo_full, accept, push, pop, found;
  logic [ID_W-1:0] last_grant, grant_id, scan_id;
  logic [ID_W-1:0] id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic error_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    system_bus_arb_lane u_lane (
      .grant       (grant[i]),
      .fifo_full   (fifo_full),
      .read_req    (mst_read_req[i]),
      .write_req   (mst_write_req[i]),
      .addr        (mst_addr[30*i +: 30]),
      .write_data  (mst_write_data[32*i +: 32]),
      .byte_enable (mst_byte_enable[4*i +: 4]),
      .eligible    (eligible[i]),
      .bus_req     (lane_req[i])
    );
  end

  // Scan order: index order in fixed mode, starting just after last_grant in round-robin.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    scan_id = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ARB_MODE == 0) scan_id = ID_W'(k);
      else               scan_id = ID_W'((int'(last_grant) + 1 + k) % NUM_MASTERS);
      if (!found && !reset && eligible[scan_id]) begin
        grant[scan_id] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  always_comb begin
    bus      = '0;
    grant_id = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus = bus | lane_req[i];
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  assign accept = (|grant) & system_bus_ready;
  assign push   = accept & bus.rd;
  assign pop    = system_bus_read_data_valid & (count != '0) & ~reset;

  assign system_bus_read_req    = bus.rd;
  assign system_bus_write_req   = bus.wr;
  assign system_bus_addr        = bus.addr;
  assign system_bus_write_data  = bus.wdata;
  assign system_bus_byte_enable = bus.be;
  assign mst_ready              = grant & {NUM_MASTERS{system_bus_ready}};
  assign mst_read_data          = system_bus_read_data;
  assign outstanding_count      = count;
  assign unexpected_read_error  = error_q;

  always_comb begin
    mst_read_data_valid = '0;
    if (pop) mst_read_data_valid[id_fifo[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      error_q    <= 1'b0;
      last_grant <= ID_W'(NUM_MASTERS - 1);
    end else begin
      if (accept) last_grant <= grant_id;
      if (push)   wr_ptr     <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr     <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (system_bus_read_data_valid && count == '0) error_q <= 1'b1;
    end
  end
endmodule
